// File: rtl/cic_pkg.sv
// Shared definitions for the CIC frame sequencer and the CIC array instantiation:
// default geometry and the sequencer state encoding.
package cic_pkg;

  localparam int unsigned CIC_N_CH     = 4;
  localparam int unsigned CIC_DW       = 32;
  localparam int unsigned CIC_SKEW_MAX = 64;
  localparam int unsigned CIC_FCW      = 16;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_EMIT    = 1'b1
  } seq_state_e;

endpackage

// File: rtl/cic_capture_slot.sv
// One channel's capture register, pending bit and sticky overrun flag.
// A new strobe always wins over a frame-latch or skew-drop clear of the pending bit.
module cic_capture_slot
  import cic_pkg::*;
#(
  parameter int unsigned DW = CIC_DW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_enable,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  input  logic          i_clr,
  input  logic          i_clear_err,
  output logic [DW-1:0] o_cap,
  output logic          o_pend,
  output logic          o_overrun
);

  logic [DW-1:0] r_cap;
  logic          r_pend;
  logic          r_overrun;
  logic          w_take;

  assign w_take = i_enable & i_valid;

  // A strobe on a clearing edge replaces a sample that is being consumed, so it is not an overrun.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cap     <= {DW{1'b0}};
      r_pend    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_take) begin
        r_cap  <= i_data;
        r_pend <= 1'b1;
      end else if (!i_enable || i_clr) begin
        r_pend <= 1'b0;
      end
      if (w_take && r_pend && !i_clr) begin
        r_overrun <= 1'b1;
      end else if (i_clear_err) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_cap     = r_cap;
  assign o_pend    = r_pend;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/cic_frame_sequencer.sv
// Aligns per-channel CIC samples into frames and streams each frame in channel order
// over valid/ready, with overrun and inter-channel skew detection.
module cic_frame_sequencer
  import cic_pkg::*;
#(
  parameter int unsigned N_CH     = CIC_N_CH,
  parameter int unsigned DW       = CIC_DW,
  parameter int unsigned SKEW_MAX = CIC_SKEW_MAX,
  parameter int unsigned FCW      = CIC_FCW
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic [N_CH*DW-1:0]      i_ch_data,
  input  logic [N_CH-1:0]         i_ch_valid,
  output logic [DW-1:0]           o_out_data,
  output logic [$clog2(N_CH)-1:0] o_out_ch,
  output logic                    o_out_last,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [N_CH-1:0]         o_overrun,
  output logic                    o_skew_err,
  input  logic                    i_clear_err,
  output logic [FCW-1:0]          o_frame_cnt
);

  localparam int unsigned CW = $clog2(N_CH);
  localparam int unsigned TW = $clog2(SKEW_MAX + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(N_CH - 1);
  localparam logic [TW-1:0] T_MAX    = TW'(SKEW_MAX);

  seq_state_e      r_state;
  seq_state_e      w_state_nxt;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_timer_nxt;
  logic [DW-1:0]   r_frm [N_CH];
  logic [CW-1:0]   r_idx;
  logic [CW-1:0]   w_idx_inc;
  logic [DW-1:0]   r_out_data;
  logic            r_out_last;
  logic            r_out_valid;
  logic            r_skew_err;
  logic [FCW-1:0]  r_frame_cnt;

  logic [DW-1:0]   w_cap [N_CH];
  logic [N_CH-1:0] w_pend;
  logic [N_CH-1:0] w_overrun;
  logic            w_all_pend;
  logic            w_partial;
  logic            w_latch;
  logic            w_drop;
  logic            w_beat;

  for (genvar g = 0; g < N_CH; g++) begin : g_slot
    cic_capture_slot #(.DW(DW)) u_slot (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_enable    (i_enable),
      .i_valid     (i_ch_valid[g]),
      .i_data      (i_ch_data[g*DW +: DW]),
      .i_clr       (w_latch | w_drop),
      .i_clear_err (i_clear_err),
      .o_cap       (w_cap[g]),
      .o_pend      (w_pend[g]),
      .o_overrun   (w_overrun[g])
    );
  end

  assign w_all_pend = i_enable & (&w_pend);
  assign w_partial  = (|w_pend) & ~(&w_pend);
  assign w_beat     = r_out_valid & i_out_ready;
  assign w_idx_inc  = r_idx + CW'(1);

  // Next state, skew timer and the frame-latch / skew-drop strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_latch     = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        if (w_all_pend) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_EMIT;
          w_timer_nxt = {TW{1'b0}};
        end else if (!i_enable) begin
          w_timer_nxt = {TW{1'b0}};
        end else if (w_partial) begin
          if (r_timer >= T_MAX) begin
            w_drop      = 1'b1;
            w_timer_nxt = {TW{1'b0}};
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end else begin
          w_timer_nxt = {TW{1'b0}};
        end
      end
      ST_EMIT: begin
        if (w_beat && r_out_last) begin
          w_state_nxt = ST_COLLECT;
        end else begin
          w_state_nxt = ST_EMIT;
        end
        if (i_enable) begin
          w_timer_nxt = r_timer;
        end else begin
          w_timer_nxt = {TW{1'b0}};
        end
      end
      default: begin
        w_state_nxt = ST_COLLECT;
        w_timer_nxt = {TW{1'b0}};
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_COLLECT;
      r_timer <= {TW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Beat 0 is taken straight from the capture registers on the latch edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        r_frm[c] <= {DW{1'b0}};
      end
      r_idx       <= {CW{1'b0}};
      r_out_data  <= {DW{1'b0}};
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_frame_cnt <= {FCW{1'b0}};
    end else if (w_latch) begin
      for (int c = 0; c < N_CH; c++) begin
        r_frm[c] <= w_cap[c];
      end
      r_idx       <= {CW{1'b0}};
      r_out_data  <= w_cap[0];
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b1;
    end else if (w_beat) begin
      if (r_out_last) begin
        r_out_valid <= 1'b0;
        r_frame_cnt <= r_frame_cnt + FCW'(1);
      end else begin
        r_idx      <= w_idx_inc;
        r_out_data <= r_frm[w_idx_inc];
        r_out_last <= (w_idx_inc == LAST_IDX);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_skew_err <= 1'b0;
    end else if (w_drop) begin
      r_skew_err <= 1'b1;
    end else if (i_clear_err) begin
      r_skew_err <= 1'b0;
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_ch    = r_idx;
  assign o_out_last  = r_out_last;
  assign o_out_valid = r_out_valid;
  assign o_overrun   = w_overrun;
  assign o_skew_err  = r_skew_err;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_cic_frame_sequencer.sv
// Scoreboard bench for cic_frame_sequencer: expected beats are queued when a frame
// is driven and compared against every valid beat observed on the falling edge.
module tb_cic_frame_sequencer;

  localparam int N_CH = 4;
  localparam int DW   = 32;
  localparam int SKEW = 64;
  localparam int FCW  = 4;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  ch;
    logic        last;
  } beat_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b1;
  logic [N_CH*DW-1:0] ch_data = '0;
  logic [N_CH-1:0]    ch_valid = '0;
  logic [DW-1:0]      out_data;
  logic [1:0]         out_ch;
  logic               out_last;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [N_CH-1:0]    overrun;
  logic               skew_err;
  logic               clear_err = 1'b0;
  logic [FCW-1:0]     frame_cnt;

  beat_t q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int exp_frames = 0;

  always #5 clk = ~clk;

  cic_frame_sequencer #(.N_CH(N_CH), .DW(DW), .SKEW_MAX(SKEW), .FCW(FCW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable),
    .i_ch_data(ch_data), .i_ch_valid(ch_valid),
    .o_out_data(out_data), .o_out_ch(out_ch), .o_out_last(out_last),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_overrun(overrun), .o_skew_err(skew_err), .i_clear_err(clear_err),
    .o_frame_cnt(frame_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] m, input logic [127:0] d);
    ch_valid = m;
    ch_data  = d;
    tick();
    ch_valid = '0;
  endtask

  task automatic push_frame(input logic [127:0] d);
    for (int c = 0; c < N_CH; c++) begin
      q.push_back('{d: d[c*32 +: 32], ch: 2'(c), last: (c == N_CH - 1)});
    end
    exp_frames++;
  endtask

  task automatic send_frame(input logic [127:0] d);
    push_frame(d);
    strobe(4'hF, d);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      tick();
      n++;
    end
    check_eq("drain_left", 32'(q.size()), 32'd0);
  endtask

  // Every valid beat, stalled or accepted, must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check_eq("beat_queued", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        check_eq("beat_data", out_data, q[0].d);
        check_eq("beat_ch", 32'(out_ch), 32'(q[0].ch));
        check_eq("beat_last", 32'(out_last), 32'(q[0].last));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    logic [127:0] d;

    // reset values
    #12;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", out_data, 32'd0);
    check_eq("rst_ch", 32'(out_ch), 32'd0);
    check_eq("rst_last", 32'(out_last), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_skew", 32'(skew_err), 32'd0);
    check_eq("rst_fcnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // aligned frame and latch latency
    send_frame({32'h13, 32'h12, 32'h11, 32'h10});
    check_eq("lat_edge_k", 32'(out_valid), 32'd0);
    tick();
    check_eq("lat_edge_k1", 32'(out_valid), 32'd1);
    drain();
    check_eq("fcnt_aligned", 32'(frame_cnt), 32'(exp_frames % 16));

    // backpressure with a second frame captured during the stall
    send_frame({32'h23, 32'h22, 32'h21, 32'h20});
    tick();
    tick();
    out_ready = 1'b0;
    tick();
    push_frame({32'h33, 32'h32, 32'h31, 32'h30});
    strobe(4'hF, {32'h33, 32'h32, 32'h31, 32'h30});
    repeat (3) tick();
    check_eq("stall_valid", 32'(out_valid), 32'd1);
    check_eq("stall_ch", 32'(out_ch), 32'd1);
    out_ready = 1'b1;
    drain();
    check_eq("fcnt_bp", 32'(frame_cnt), 32'(exp_frames % 16));

    // overrun on ch2
    strobe(4'b0100, {32'h0, 32'hA, 32'h0, 32'h0});
    strobe(4'b0100, {32'h0, 32'hB, 32'h0, 32'h0});
    check_eq("ovr_set", 32'(overrun), 32'h4);
    d = {32'h43, 32'h0B, 32'h41, 32'h40};
    push_frame(d);
    strobe(4'b1011, d);
    drain();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check_eq("ovr_clear", 32'(overrun), 32'h0);

    // skew drop after a partial frame
    strobe(4'b0011, {32'h0, 32'h0, 32'h51, 32'h50});
    repeat (60) tick();
    check_eq("skew_early", 32'(skew_err), 32'd0);
    repeat (8) tick();
    check_eq("skew_set", 32'(skew_err), 32'd1);
    d = {32'h63, 32'h62, 32'h61, 32'h60};
    strobe(4'b1100, d);
    repeat (3) tick();
    check_eq("skew_pend_clr", 32'(out_valid), 32'd0);
    push_frame(d);
    strobe(4'b0011, d);
    drain();
    check_eq("fcnt_skew", 32'(frame_cnt), 32'(exp_frames % 16));
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check_eq("skew_clear", 32'(skew_err), 32'd0);

    // ch1 strobe on the frame-latch edge
    send_frame({32'h73, 32'h72, 32'h71, 32'h70});
    strobe(4'b0010, {32'h0, 32'h0, 32'h81, 32'h0});
    drain();
    check_eq("coll_no_ovr", 32'(overrun), 32'h0);
    d = {32'h83, 32'h82, 32'h81, 32'h80};
    push_frame(d);
    strobe(4'b1101, d);
    drain();

    // frame counter wrap
    while (exp_frames % 16 != 0) begin
      send_frame({$urandom(), $urandom(), $urandom(), $urandom()});
      drain();
    end
    check_eq("fcnt_wrap", 32'(frame_cnt), 32'd0);

    // async reset during beat 2
    strobe(4'b1000, {32'h1, 32'h0, 32'h0, 32'h0});
    d = {32'h93, 32'h92, 32'h91, 32'h90};
    strobe(4'b1000, d);
    out_ready = 1'b0;
    push_frame(d);
    strobe(4'b0111, d);
    tick();
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check_eq("pre_rst_ch", 32'(out_ch), 32'd2);
    check_eq("pre_rst_ovr", 32'(overrun), 32'h8);
    #2;
    rst_n = 1'b0;
    q.delete();
    exp_frames = 0;
    #1;
    check_eq("arst_valid", 32'(out_valid), 32'd0);
    check_eq("arst_ch", 32'(out_ch), 32'd0);
    check_eq("arst_ovr", 32'(overrun), 32'h0);
    check_eq("arst_fcnt", 32'(frame_cnt), 32'd0);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // enable low discards a partial frame and ignores strobes
    strobe(4'b0011, {32'h0, 32'h0, 32'hB1, 32'hB0});
    enable = 1'b0;
    strobe(4'hF, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    strobe(4'hF, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    enable = 1'b1;
    strobe(4'b1100, {32'hD3, 32'hD2, 32'h0, 32'h0});
    repeat (3) tick();
    check_eq("en_no_frame", 32'(out_valid), 32'd0);
    d = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    push_frame(d);
    strobe(4'b0011, d);
    drain();
    check_eq("fcnt_final", 32'(frame_cnt), 32'(exp_frames % 16));
    check_eq("skew_final", 32'(skew_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
